// File: rtl/fd_pkg.sv
// Shared definitions for the frame-data readers: FSM encoding, bus stride and counter width.
package fd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 16;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   sum_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: head always presents the oldest entry, count reports occupancy.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the same cycle pops.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/image_reader.sv
// Reads one frame of NUM_WORDS 32-bit words over Avalon-MM and streams them out in address order.
module image_reader
  import fd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_WORDS  = 19200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iStart,
  output logic [31:0] oAddr_IR,
  output logic        oRdreq_IR,
  input  logic        iRead_wait_request,
  input  logic        iRead_data_valid,
  input  logic [31:0] iData_IR,
  input  logic        iSink_ready,
  output logic        oInput_ready,
  output logic [31:0] oData_out,
  output logic        oBusy,
  output logic        oFinish
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam cnt_t        NUM      = cnt_t'(NUM_WORDS);
  localparam cnt_t        LAST_IDX = cnt_t'(NUM_WORDS - 1);
  localparam sum_t        DEPTH_W  = sum_t'(FIFO_DEPTH);

  state_t        state;
  cnt_t          issued;
  cnt_t          delivered;
  cnt_t          outstanding;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [31:0]   head;
  sum_t          inflight;
  logic          active;
  logic          accept;
  logic          push;
  logic          pop;

  assign active   = (state == S_READ) || (state == S_DRAIN);
  // Words already buffered plus words still on the bus must fit in the FIFO.
  assign inflight = sum_t'(outstanding) + sum_t'(fifo_count);

  assign oRdreq_IR    = (state == S_READ) && (issued < NUM) && (inflight < DEPTH_W);
  assign accept       = oRdreq_IR && !iRead_wait_request;
  // Responses with nothing outstanding belong to reads cut off by a reset.
  assign push         = iRead_data_valid && active && (outstanding != '0);
  assign oInput_ready = !fifo_empty;
  assign pop          = oInput_ready && iSink_ready;
  assign oData_out    = fifo_empty ? '0 : head;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iClk),
    .reset     (iReset),
    .push      (push),
    .push_data (iData_IR),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state       <= S_IDLE;
      issued      <= '0;
      delivered   <= '0;
      outstanding <= '0;
      oAddr_IR    <= BASE_ADDR;
      oBusy       <= 1'b0;
      oFinish     <= 1'b0;
    end else begin
      oFinish <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (iStart) begin
            state       <= S_READ;
            issued      <= '0;
            delivered   <= '0;
            outstanding <= '0;
            oAddr_IR    <= BASE_ADDR;
            oBusy       <= 1'b1;
          end
        end
        S_READ, S_DRAIN: begin
          if (accept) begin
            oAddr_IR <= oAddr_IR + WORD_BYTES;
            issued   <= issued + 1'b1;
          end
          if (accept && !push)      outstanding <= outstanding + 1'b1;
          else if (push && !accept) outstanding <= outstanding - 1'b1;
          if (pop) delivered <= delivered + 1'b1;
          if (state == S_READ && issued == NUM) state <= S_DRAIN;
          if (state == S_DRAIN && pop && delivered == LAST_IDX) begin
            state   <= S_DONE;
            oFinish <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          oBusy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/image_reader.md
IMAGE_READER -- requirements
Module: image_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first image word.
REQ-002 SHALL have parameter NUM_WORDS, default 19200, number of 32-bit words per frame (range 1..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two, range 4..64.
REQ-004 iClk  in  1  single clock; all logic is rising-edge.
REQ-005 iReset  in  1  reset, synchronous to iClk, active-high.
REQ-006 iStart  in  1  one-cycle pulse that starts one frame read; ignored unless idle.
REQ-007 oAddr_IR  out  32  Avalon-MM read address, byte address.
REQ-008 oRdreq_IR  out  1  Avalon-MM read request.
REQ-009 iRead_wait_request  in  1  Avalon-MM waitrequest.
REQ-010 iRead_data_valid  in  1  Avalon-MM readdatavalid.
REQ-011 iData_IR  in  32  Avalon-MM readdata.
REQ-012 iSink_ready  in  1  downstream accepts a word this cycle.
REQ-013 oInput_ready  out  1  oData_out is valid; transfer occurs when oInput_ready and iSink_ready are both high.
REQ-014 oData_out  out  32  image word toward the pre-processing stage.
REQ-015 oBusy  out  1  high from the accepted iStart until oFinish.
REQ-016 oFinish  out  1  one-cycle pulse after the last word transfers downstream.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE->READ on iStart; clears issue, receive and delivery counters and loads the address to BASE_ADDR.
REQ-019 In READ, oRdreq_IR SHALL be high when issued < NUM_WORDS and (fifo_count + outstanding) < FIFO_DEPTH.
REQ-020 A read is accepted when oRdreq_IR=1 and iRead_wait_request=0; oAddr_IR then advances by 4 and issued increments.
REQ-021 While iRead_wait_request=1, oAddr_IR and oRdreq_IR SHALL hold stable.
REQ-022 outstanding SHALL increment on an accepted read and decrement on iRead_data_valid; when both occur in the same cycle it is unchanged.
REQ-023 Each iRead_data_valid SHALL push iData_IR into the FIFO; an overflow cannot occur because of REQ-019.
REQ-024 READ->DRAIN when issued = NUM_WORDS; oRdreq_IR SHALL be low in DRAIN.
REQ-025 oInput_ready SHALL equal FIFO not-empty; oData_out SHALL be the FIFO head (show-ahead, zero added latency).
REQ-026 Each transfer SHALL pop the FIFO and increment delivered; a simultaneous push and pop SHALL leave the count unchanged.
REQ-027 DRAIN->DONE when delivered reaches NUM_WORDS; DONE asserts oFinish for one cycle and then goes to IDLE.
REQ-028 An iStart in any state other than IDLE SHALL be ignored.
REQ-029 Minimum latency from the first iRead_data_valid to oInput_ready SHALL be 1 cycle.
REQ-030 Data SHALL leave in address order with no loss or duplication, regardless of wait-request or sink stalls.
REQ-031 Counters SHALL be 16 bits; oAddr_IR SHALL wrap modulo 2^32.

Reset
REQ-032 On iReset=1 at a clock edge: state=IDLE, counters=0, FIFO empty, oAddr_IR=BASE_ADDR, oRdreq_IR=0, oInput_ready=0, oData_out=0, oBusy=0, oFinish=0.
REQ-033 Reset during a frame SHALL abort it without an oFinish pulse.
REQ-034 After reset, iRead_data_valid responses to reads issued before reset SHALL be discarded; the system holds the slave in reset too.

Structure
REQ-035 State encoding, the word-byte stride (4) and the counter width SHALL live in shared package fd_pkg.
REQ-036 The FIFO SHALL be the separate sub-module sync_fifo (show-ahead, count output), parameterised by width and depth.

Verification
REQ-038 Frame with no stalls (NUM_WORDS=16, zero-wait slave, 2-cycle read latency, iSink_ready=1) -> words 0..15 out in order, addresses BASE..BASE+60, oFinish exactly once.
REQ-039 Random iRead_wait_request at 50% -> address and request held while stalled; output sequence identical to the no-stall case.
REQ-040 iSink_ready=0 for 40 cycles -> at most FIFO_DEPTH reads issued and outstanding; resumes without loss.
REQ-041 NUM_WORDS=1 -> one read issued, one transfer, oFinish on the cycle after the transfer.
REQ-042 Reset asserted mid-frame after 5 transfers -> all outputs at reset values next cycle, no oFinish; a new iStart reads the full frame again.
REQ-043 iStart pulsed while busy -> ignored; single frame of NUM_WORDS words delivered.
